// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: comma preamble after reset, then MSB-first bytes, 8 clk_32f cycles each.
// Latency: byte loaded on a load edge appears on data_out the next cycle; ready_out is decoded from registered state only.
module paralelo_serial_tx #(
    parameter int          SYNC_BYTES = 4,
    parameter logic [7:0]  COMMA      = 8'hBC
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       active_out,
    output logic [7:0] data_count
);

    typedef enum logic {SYNC, RUN} state_t;

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_BYTES - 1);

    state_t     state_q;
    logic [3:0] sync_cnt_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shreg_q;
    logic [7:0] data_count_q;
    logic       load_edge;

    assign load_edge = (bit_cnt_q == 3'd7);

    // Reset parks bit_cnt at 7 so the first edge after release is a load edge.
    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            state_q      <= SYNC;
            sync_cnt_q   <= 4'd0;
            bit_cnt_q    <= 3'd7;
            shreg_q      <= 8'h00;
            data_count_q <= 8'd0;
        end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (load_edge) begin
                case (state_q)
                    SYNC: begin
                        shreg_q    <= COMMA;
                        sync_cnt_q <= sync_cnt_q + 4'd1;
                        if (sync_cnt_q == SYNC_LAST)
                            state_q <= RUN;
                    end
                    RUN: begin
                        if (valid_in) begin
                            shreg_q      <= data_in;
                            data_count_q <= data_count_q + 8'd1;
                        end else begin
                            shreg_q <= COMMA;
                        end
                    end
                    default: state_q <= SYNC;
                endcase
            end else begin
                shreg_q <= {shreg_q[6:0], 1'b0};
            end
        end
    end

    assign data_out   = shreg_q[7];
    assign active_out = (state_q == RUN);
    assign ready_out  = (state_q == RUN) && load_edge;
    assign data_count = data_count_q;

endmodule
